// File: rtl/io_out_fifo.sv
// Output-side FIFO behind the processor I/O write port: buffers {addr, data}
// writes and drains them to a consumer over a show-ahead valid/ready interface.
module io_out_fifo #(
    parameter int NUBITS = 16,
    parameter int NUIOOU = 2,
    parameter int NBADDR = $clog2(NUIOOU),
    parameter int FDEPTH = 8,
    parameter int NBCNT  = $clog2(FDEPTH) + 1,
    parameter int AFTHR  = FDEPTH - 2,
    parameter int NBDROP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_en,
    input  logic [NBADDR-1:0] addr_out,
    input  logic [NUBITS-1:0] io_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [NBADDR-1:0] m_addr,
    output logic [NUBITS-1:0] m_data,
    output logic [NBCNT-1:0]  count,
    output logic              afull,
    output logic              full,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [NBDROP-1:0] drop_cnt
);

    localparam int NBPTR = $clog2(FDEPTH);

    logic [NBADDR-1:0] r_mem_addr [FDEPTH];
    logic [NUBITS-1:0] r_mem_data [FDEPTH];
    logic [NBPTR-1:0]  r_wptr;
    logic [NBPTR-1:0]  r_rptr;
    logic [NBCNT-1:0]  r_count;
    logic              r_ovf;
    logic [NBDROP-1:0] r_drop;

    logic w_rd;
    logic w_wr;
    logic w_drop;

    assign m_valid  = (r_count != '0);
    assign full     = (r_count == NBCNT'(FDEPTH));
    assign afull    = (r_count >= NBCNT'(AFTHR));
    assign count    = r_count;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop;

    // Show-ahead: the head is read straight from the array, no bypass of the write.
    assign m_addr = r_mem_addr[r_rptr];
    assign m_data = r_mem_data[r_rptr];

    assign w_rd   = m_valid & m_ready;
    assign w_wr   = out_en & (~full | w_rd);
    assign w_drop = out_en & full & ~w_rd;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_addr[r_wptr] <= addr_out;
            r_mem_data[r_wptr] <= io_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + NBPTR'(1);
            if (w_rd) r_rptr <= r_rptr + NBPTR'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + NBCNT'(1);
                2'b01:   r_count <= r_count - NBCNT'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr)
                r_drop <= NBDROP'(1);
            else if (r_drop != '1)
                r_drop <= r_drop + NBDROP'(1);
        end else if (ovf_clr) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end
    end

endmodule
